// File: rtl/mtimer_pkg.sv
// Shared constants for the mtimer_clint machine timer: register offsets,
// ctrl bit positions and the mtimecmp reset value.
package mtimer_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;
    localparam logic [4:0] PERIOD_OFF      = 5'h14;

    // Word indices used by the decoder; the low two address bits never matter.
    localparam logic [2:0] MTIME_LO_W    = MTIME_LO_OFF[4:2];
    localparam logic [2:0] MTIME_HI_W    = MTIME_HI_OFF[4:2];
    localparam logic [2:0] MTIMECMP_LO_W = MTIMECMP_LO_OFF[4:2];
    localparam logic [2:0] MTIMECMP_HI_W = MTIMECMP_HI_OFF[4:2];
    localparam logic [2:0] CTRL_W        = CTRL_OFF[4:2];
    localparam logic [2:0] PERIOD_W      = PERIOD_OFF[4:2];

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MASK_BIT   = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtimer_clint_if.sv
// Single-cycle load/store register port of the machine timer.
interface mtimer_clint_if;

    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output sel, we, addr, wdata, input rdata, rvalid);
    modport slave  (input sel, we, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; the count freezes (not clears) when disabled.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer_clint.sv
// RISC-V machine timer (mtime/mtimecmp) with a registered level interrupt.
// Define MTIMER_AUTORELOAD_EN to add the period register and automatic mtimecmp reload.
module mtimer_clint #(
    parameter int PRESCALE = 1,
    parameter bit RST_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    mtimer_clint_if.slave   bus,
    output logic            timer_interrupt
);

    import mtimer_pkg::*;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        enable;
    logic        irq_mask;
    logic        tick;
    logic        wr;
    logic        rd;
    logic [2:0]  word;
    logic        irq_next;
    logic [31:0] read_mux;
    logic        unused_addr_bits;

    assign word             = bus.addr[4:2];
    assign wr               = bus.sel && bus.we;
    assign rd               = bus.sel && !bus.we;
    assign irq_next         = !irq_mask && (mtime >= mtimecmp);
    assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

`ifdef MTIMER_AUTORELOAD_EN
    logic [31:0] period;
    logic        reload;

    // Reload only on the rising edge of the next interrupt value.
    assign reload = irq_next && !timer_interrupt && (period != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
        end else if (wr && word == PERIOD_W) begin
            period <= bus.wdata;
        end
    end
`endif

    // A software write to either half beats the tick; the other half holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr && word == MTIME_LO_W) begin
            mtime[31:0] <= bus.wdata;
        end else if (wr && word == MTIME_HI_W) begin
            mtime[63:32] <= bus.wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr && word == MTIMECMP_LO_W) begin
            mtimecmp[31:0] <= bus.wdata;
        end else if (wr && word == MTIMECMP_HI_W) begin
            mtimecmp[63:32] <= bus.wdata;
`ifdef MTIMER_AUTORELOAD_EN
        end else if (reload) begin
            mtimecmp <= mtimecmp + {32'd0, period};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= RST_EN;
            irq_mask <= 1'b0;
        end else if (wr && word == CTRL_W) begin
            enable   <= bus.wdata[CTRL_ENABLE_BIT];
            irq_mask <= bus.wdata[CTRL_MASK_BIT];
        end
    end

    always_comb begin
        read_mux = '0;
        case (word)
            MTIME_LO_W:    read_mux = mtime[31:0];
            MTIME_HI_W:    read_mux = mtime[63:32];
            MTIMECMP_LO_W: read_mux = mtimecmp[31:0];
            MTIMECMP_HI_W: read_mux = mtimecmp[63:32];
            CTRL_W: begin
                read_mux[CTRL_ENABLE_BIT] = enable;
                read_mux[CTRL_MASK_BIT]   = irq_mask;
            end
`ifdef MTIMER_AUTORELOAD_EN
            PERIOD_W:      read_mux = period;
`endif
            default:       read_mux = '0;
        endcase
    end

    // rdata keeps the last read value until the next read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata       <= '0;
            bus.rvalid      <= 1'b0;
            timer_interrupt <= 1'b0;
        end else begin
            bus.rvalid      <= rd;
            timer_interrupt <= irq_next;
            if (rd) begin
                bus.rdata <= read_mux;
            end
        end
    end

endmodule

// File: tb/tb_mtimer_clint.sv
// Self-checking bench for mtimer_clint: DUT A (PRESCALE=1, RST_EN=1) is tracked by a
// behavioural model; DUT B (PRESCALE=4, RST_EN=0) checks prescaling and freezing.
module tb_mtimer_clint;

    localparam int PRESCALE_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq_a;
    logic irq_b;
    int   checks = 0;
    int   errors = 0;

    mtimer_clint_if bus_a ();
    mtimer_clint_if bus_b ();

    mtimer_clint #(.PRESCALE(PRESCALE_A), .RST_EN(1'b1)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_a),
        .timer_interrupt (irq_a)
    );

    mtimer_clint #(.PRESCALE(4), .RST_EN(1'b0)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_b),
        .timer_interrupt (irq_b)
    );

    always #5 clk = ~clk;

    // Reference model of DUT A, stepped once per rising clock edge.
    logic [63:0] m_time, m_cmp, m_next_time, m_next_cmp;
    logic        m_en, m_mask, m_irq, m_irq_new, m_rvalid, m_wr, m_tick;
    logic [31:0] m_rdata;
    int          m_pc, m_idx;
`ifdef MTIMER_AUTORELOAD_EN
    logic [31:0] m_period;
`endif

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return m_time[31:0];
            1: return m_time[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_mask, m_en};
`ifdef MTIMER_AUTORELOAD_EN
            5: return m_period;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en = 1'b1; m_mask = 1'b0; m_irq = 1'b0; m_pc = 0;
            m_rdata = 32'd0; m_rvalid = 1'b0;
`ifdef MTIMER_AUTORELOAD_EN
            m_period = 32'd0;
`endif
        end else begin
            m_irq_new = !m_mask && (m_time >= m_cmp);
            m_idx = int'(bus_a.addr[4:2]);
            m_wr = bus_a.sel && bus_a.we;
            if (bus_a.sel && !bus_a.we) begin
                m_rdata = model_read(m_idx);
                m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            m_tick = 1'b0;
            if (m_en) begin
                if (m_pc == PRESCALE_A - 1) begin m_tick = 1'b1; m_pc = 0; end
                else m_pc = m_pc + 1;
            end
            m_next_time = m_time;
            if (m_wr && m_idx == 0) m_next_time[31:0] = bus_a.wdata;
            else if (m_wr && m_idx == 1) m_next_time[63:32] = bus_a.wdata;
            else if (m_tick) m_next_time = m_time + 64'd1;
            m_next_cmp = m_cmp;
            if (m_wr && m_idx == 2) m_next_cmp[31:0] = bus_a.wdata;
            else if (m_wr && m_idx == 3) m_next_cmp[63:32] = bus_a.wdata;
`ifdef MTIMER_AUTORELOAD_EN
            else if (m_irq_new && !m_irq && m_period != 32'd0) m_next_cmp = m_cmp + {32'd0, m_period};
            if (m_wr && m_idx == 5) m_period = bus_a.wdata;
`endif
            if (m_wr && m_idx == 4) begin m_en = bus_a.wdata[0]; m_mask = bus_a.wdata[1]; end
            m_time = m_next_time;
            m_cmp = m_next_cmp;
            m_irq = m_irq_new;
        end
    end

    task automatic bus_write(input int which, input logic [4:0] a, input logic [31:0] d);
        if (which == 0) begin bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.wdata = d; end
        else begin bus_b.sel = 1'b1; bus_b.we = 1'b1; bus_b.addr = a; bus_b.wdata = d; end
        @(negedge clk);
        bus_a.sel = 1'b0; bus_b.sel = 1'b0; bus_a.we = 1'b0; bus_b.we = 1'b0;
    endtask

    task automatic bus_read(input int which, input logic [4:0] a, output logic [31:0] d, output logic v);
        if (which == 0) begin bus_a.sel = 1'b1; bus_a.we = 1'b0; bus_a.addr = a; end
        else begin bus_b.sel = 1'b1; bus_b.we = 1'b0; bus_b.addr = a; end
        @(negedge clk);
        bus_a.sel = 1'b0; bus_b.sel = 1'b0;
        d = (which == 0) ? bus_a.rdata : bus_b.rdata;
        v = (which == 0) ? bus_a.rvalid : bus_b.rvalid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        repeat (3) @(negedge clk);
        checks++;
        if (irq_a !== 1'b0 || bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got irq=%b rvalid=%b rdata=%h expected 0/0/0", irq_a, bus_a.rvalid, bus_a.rdata);
        end
        rst = 1'b0;
        bus_read(0, 5'h08, d, v);
        checks++;
        if (d !== 32'hFFFF_FFFF || v !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_cmp_lo: got %h/%b expected ffffffff/1", d, v);
        end
        bus_read(0, 5'h0C, d, v);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_cmp_hi: got %h expected ffffffff", d); end
        bus_read(0, 5'h10, d, v);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL reset_ctrl_a: got %h expected 1", d); end
        bus_read(1, 5'h10, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl_b: got %h expected 0", d); end
        bus_read(0, 5'h1C, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 0", d); end
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== m_rdata) begin errors++; $display("[TB] FAIL reset_mtime_lo: got %h expected %h", d, m_rdata); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic        v;
        bus_write(1, 5'h10, 32'h1);
        repeat (39) @(negedge clk);
        bus_write(1, 5'h10, 32'h0);
        bus_read(1, 5'h00, d, v);
        checks++;
        if (d !== 32'd10) begin errors++; $display("[TB] FAIL prescale_count: got %0d expected 10", d); end
        bus_read(1, 5'h04, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL prescale_hi: got %h expected 0", d); end
        repeat (20) @(negedge clk);
        bus_read(1, 5'h00, d, v);
        checks++;
        if (d !== 32'd10) begin errors++; $display("[TB] FAIL prescale_frozen: got %0d expected 10", d); end
        checks++;
        if (irq_b !== 1'b0) begin errors++; $display("[TB] FAIL prescale_irq: got %b expected 0", irq_b); end
    endtask

    task automatic test_compare_irq();
        logic [31:0] d;
        logic        v;
        bit          seen = 1'b0;
        do_reset();
        bus_write(0, 5'h0C, 32'h0);
        bus_write(0, 5'h08, 32'h14);
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (irq_a !== m_irq) begin errors++; $display("[TB] FAIL cmp_irq_track: got %b expected %b", irq_a, m_irq); end
            if (irq_a === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL cmp_irq_timeout: got no interrupt expected one within 64 cycles"); end
        // Interrupt becomes visible the cycle mtime advances past 0x14, so the next sample is 0x15.
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== 32'h15 || v !== 1'b1) begin errors++; $display("[TB] FAIL cmp_irq_edge: got %h/%b expected 15/1", d, v); end
    endtask

    task automatic test_clear();
        bus_write(0, 5'h0C, 32'hFFFF_FFFF);
        checks++;
        if (irq_a !== 1'b1) begin errors++; $display("[TB] FAIL clear_hold: got %b expected 1", irq_a); end
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b0 || m_irq !== 1'b0) begin errors++; $display("[TB] FAIL clear_drop: got %b expected 0", irq_a); end
    endtask

    task automatic test_tick_collision();
        logic [31:0] d;
        logic        v;
        bus_write(0, 5'h00, 32'h0000_1234);
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== 32'h0000_1234) begin errors++; $display("[TB] FAIL collision_lo: got %h expected 00001234", d); end
        bus_read(0, 5'h04, d, v);
        checks++;
        if (d !== m_rdata) begin errors++; $display("[TB] FAIL collision_hi: got %h expected %h", d, m_rdata); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic        v;
        do_reset();
        bus_write(0, 5'h04, 32'hFFFF_FFFF);
        bus_write(0, 5'h00, 32'hFFFF_FFFE);
        // mtime equal to the all-ones mtimecmp satisfies >=, so the model predicts a 1-cycle pulse.
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (irq_a !== m_irq) begin errors++; $display("[TB] FAIL wrap_irq: got %b expected %b", irq_a, m_irq); end
        end
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL wrap_lo: got %h expected 1", d); end
        bus_read(0, 5'h04, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL wrap_hi: got %h expected 0", d); end
    endtask

`ifdef MTIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [31:0] d;
        logic        v;
        int rises[$];
        int width = 0;
        logic prev = 1'b0;
        do_reset();
        bus_write(0, 5'h14, 32'd5);
        bus_write(0, 5'h0C, 32'd0);
        bus_write(0, 5'h08, 32'd10);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (irq_a !== m_irq) begin errors++; $display("[TB] FAIL reload_track: got %b expected %b", irq_a, m_irq); end
            if (irq_a === 1'b1 && prev === 1'b0) rises.push_back(i);
            if (irq_a === 1'b1) width++;
            prev = irq_a;
            if (rises.size() == 3 && irq_a === 1'b0) break;
        end
        checks++;
        if (rises.size() != 3 || width != 3) begin
            errors++; $display("[TB] FAIL reload_pulses: got %0d pulses %0d high cycles expected 3/3", rises.size(), width);
        end else if (rises[1] - rises[0] != 5 || rises[2] - rises[1] != 5) begin
            errors++; $display("[TB] FAIL reload_spacing: got %0d,%0d expected 5,5", rises[1] - rises[0], rises[2] - rises[1]);
        end
        bus_read(0, 5'h08, d, v);
        checks++;
        if (d !== 32'd25) begin errors++; $display("[TB] FAIL reload_cmp: got %0d expected 25", d); end
    endtask
`else
    task automatic test_period_absent();
        logic [31:0] d;
        logic        v;
        bus_write(0, 5'h14, 32'd5);
        bus_read(0, 5'h14, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL period_absent: got %h expected 0", d); end
    endtask
`endif

    task automatic test_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            bus_a.sel = 1'b1;
            bus_a.we  = 1'b1;
            case (op)
                0, 1, 2, 3: begin bus_a.we = 1'b0; bus_a.addr = 5'($urandom_range(0, 7) * 4); end
                4: begin
                    bus_a.addr = 5'h10; bus_a.wdata = $urandom;
                    bus_a.wdata[0] = ($urandom_range(0, 3) != 0);
                    bus_a.wdata[1] = ($urandom_range(0, 3) == 0);
                end
                5: begin bus_a.addr = 5'h08; bus_a.wdata = m_time[31:0] + 32'($urandom_range(0, 20)); end
                6: begin bus_a.addr = 5'h0C; bus_a.wdata = m_time[63:32] + 32'($urandom_range(0, 3) == 0); end
                7: begin bus_a.addr = 5'h00; bus_a.wdata = 32'($urandom_range(0, 40)); end
                8: begin bus_a.addr = 5'h14; bus_a.wdata = 32'($urandom_range(0, 7)); end
                default: bus_a.sel = 1'b0;
            endcase
            @(negedge clk);
            bus_a.sel = 1'b0;
            checks++;
            if (irq_a !== m_irq || bus_a.rvalid !== m_rvalid || bus_a.rdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL random_step%0d: got irq=%b rvalid=%b rdata=%h expected %b/%b/%h",
                         i, irq_a, bus_a.rvalid, bus_a.rdata, m_irq, m_rvalid, m_rdata);
            end
        end
    endtask

    task automatic test_reset_read();
        logic [31:0] d;
        logic        v;
        bus_write(0, 5'h10, 32'h1);
        bus_write(0, 5'h00, 32'h0000_ABCD);
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== 32'h0000_ABCD) begin errors++; $display("[TB] FAIL preload_read: got %h expected 0000abcd", d); end
        bus_a.sel = 1'b1; bus_a.we = 1'b0; bus_a.addr = 5'h00;
        rst = 1'b1;
        @(negedge clk);
        bus_a.sel = 1'b0;
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_inflight: got %b/%h expected 0/0", bus_a.rvalid, bus_a.rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL release_rvalid: got %b expected 0", bus_a.rvalid); end
        bus_read(0, 5'h00, d, v);
        checks++;
        if (d !== 32'd1) begin errors++; $display("[TB] FAIL release_mtime_a: got %h expected 1", d); end
        bus_read(1, 5'h00, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL release_mtime_b: got %h expected 0", d); end
    endtask

    initial begin
        bus_a.sel = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.sel = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        $display("[TB] starting mtimer_clint bench");
        test_reset();
        test_prescale();
        test_compare_irq();
        test_clear();
        test_tick_collision();
        test_wrap();
`ifdef MTIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_period_absent();
`endif
        test_random();
        test_reset_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
